// File: rtl/mips_pkg.sv
// ============================================================================
// Module  : mips_pkg
// Brief   : Opcodes, control-bundle layout, ALU-op encodings and NOP for ID.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mips_pkg;

    localparam int          CTRL_W   = 9;
    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam int CTRL_REGWRITE = 8;
    localparam int CTRL_MEMREAD  = 7;
    localparam int CTRL_MEMWRITE = 6;
    localparam int CTRL_MEMTOREG = 5;
    localparam int CTRL_ALUSRC   = 4;
    localparam int CTRL_REGDST   = 3;
    localparam int CTRL_ALUOP_LO = 0;

    typedef enum logic [2:0] {
        ALUOP_NONE = 3'b000,
        ALUOP_ADD  = 3'b001,
        ALUOP_SUB  = 3'b010,
        ALUOP_R    = 3'b100
    } aluop_e;

    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

`default_nettype wire

// File: rtl/id_stage_if.sv
// ============================================================================
// Module  : id_stage_if
// Brief   : Fetch, write-back, EX-feedback and ID/EX bus of the decode stage.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface id_stage_if #(
    parameter int CTRL_W = 9
);
    logic [31:0]       IFtoID_PC;
    logic [31:0]       IFtoID_inst;
    logic              wb_we;
    logic [4:0]        wb_addr;
    logic [31:0]       wb_data;
    logic              ex_regWrite;
    logic              ex_memRead;
    logic [4:0]        ex_dest;
    logic              PCWrite;
    logic              branch;
    logic [31:0]       branchAddress;
    logic              jump;
    logic [31:0]       jumpAddress;
    logic [31:0]       IDtoEX_PC;
    logic [31:0]       IDtoEX_rsData;
    logic [31:0]       IDtoEX_rtData;
    logic [31:0]       IDtoEX_imm;
    logic [4:0]        IDtoEX_rs;
    logic [4:0]        IDtoEX_rt;
    logic [4:0]        IDtoEX_rd;
    logic [CTRL_W-1:0] IDtoEX_ctrl;

    modport slave (
        input  IFtoID_PC, IFtoID_inst, wb_we, wb_addr, wb_data,
               ex_regWrite, ex_memRead, ex_dest,
        output PCWrite, branch, branchAddress, jump, jumpAddress,
               IDtoEX_PC, IDtoEX_rsData, IDtoEX_rtData, IDtoEX_imm,
               IDtoEX_rs, IDtoEX_rt, IDtoEX_rd, IDtoEX_ctrl
    );

    modport master (
        output IFtoID_PC, IFtoID_inst, wb_we, wb_addr, wb_data,
               ex_regWrite, ex_memRead, ex_dest,
        input  PCWrite, branch, branchAddress, jump, jumpAddress,
               IDtoEX_PC, IDtoEX_rsData, IDtoEX_rtData, IDtoEX_imm,
               IDtoEX_rs, IDtoEX_rt, IDtoEX_rd, IDtoEX_ctrl
    );
endinterface

`default_nettype wire

// File: rtl/id_stage_register_file.sv
// ============================================================================
// Module  : register_file
// Brief   : 32x32 GPR file, 2 async reads, 1 sync write, write-first bypass.
// Revision: 1.0
// ============================================================================
`default_nettype none

module register_file (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        i_we,
    input  wire logic [4:0]  i_waddr,
    input  wire logic [31:0] i_wdata,
    input  wire logic [4:0]  i_raddr1,
    input  wire logic [4:0]  i_raddr2,
    output logic      [31:0] o_rdata1,
    output logic      [31:0] o_rdata2
);

    logic [31:0] r_gpr [32];
    logic        w_wr_en;

    assign w_wr_en = i_we && (i_waddr != 5'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_gpr[i] <= 32'd0;
            end
        end else if (w_wr_en) begin
            r_gpr[i_waddr] <= i_wdata;
        end
    end

    always_comb begin
        o_rdata1 = r_gpr[i_raddr1];
        o_rdata2 = r_gpr[i_raddr2];
        if (w_wr_en && (i_waddr == i_raddr1)) o_rdata1 = i_wdata;
        if (w_wr_en && (i_waddr == i_raddr2)) o_rdata2 = i_wdata;
        if (i_raddr1 == 5'd0) o_rdata1 = 32'd0;
        if (i_raddr2 == 5'd0) o_rdata2 = 32'd0;
    end

endmodule

`default_nettype wire

// File: rtl/id_stage.sv
// ============================================================================
// Module  : id_stage
// Brief   : MIPS decode stage: IF/ID reg, GPRs, decoder, hazards, branch/jump.
// Revision: 1.0
// ============================================================================
`default_nettype none

module id_stage
    import mips_pkg::*;
#(
    parameter int          CTRL_W   = mips_pkg::CTRL_W,
    parameter logic [31:0] NOP_INST = mips_pkg::NOP_INST
) (
    input wire logic clk,
    input wire logic rst,
    id_stage_if.slave bus
);

    logic [31:0]       r_ifid_pc;
    logic [31:0]       r_ifid_inst;
    logic [31:0]       r_idex_pc;
    logic [31:0]       r_idex_rs_data;
    logic [31:0]       r_idex_rt_data;
    logic [31:0]       r_idex_imm;
    logic [4:0]        r_idex_rs;
    logic [4:0]        r_idex_rt;
    logic [4:0]        r_idex_rd;
    logic [CTRL_W-1:0] r_idex_ctrl;

    logic [5:0]        w_op;
    logic [4:0]        w_rs;
    logic [4:0]        w_rt;
    logic [4:0]        w_rd;
    logic [31:0]       w_imm;
    logic [31:0]       w_pc4;
    logic [31:0]       w_rs_data;
    logic [31:0]       w_rt_data;
    logic [CTRL_W-1:0] w_ctrl;
    logic              w_is_beq;
    logic              w_is_bne;
    logic              w_is_j;
    logic              w_uses_rt;
    logic              w_load_use;
    logic              w_br_hazard;
    logic              w_stall;
    logic              w_taken;
    logic              w_jump;
    logic              w_flush;

    assign w_op  = r_ifid_inst[31:26];
    assign w_rs  = r_ifid_inst[25:21];
    assign w_rt  = r_ifid_inst[20:16];
    assign w_rd  = r_ifid_inst[15:11];
    assign w_imm = sext16(r_ifid_inst[15:0]);
    assign w_pc4 = r_ifid_pc + 32'd4;

    register_file u_rf (
        .clk      (clk),
        .rst      (rst),
        .i_we     (bus.wb_we),
        .i_waddr  (bus.wb_addr),
        .i_wdata  (bus.wb_data),
        .i_raddr1 (w_rs),
        .i_raddr2 (w_rt),
        .o_rdata1 (w_rs_data),
        .o_rdata2 (w_rt_data)
    );

    // The all-zero NOP decodes to an empty bundle so flushed slots carry ctrl=0.
    always_comb begin
        w_ctrl    = '0;
        w_is_beq  = 1'b0;
        w_is_bne  = 1'b0;
        w_is_j    = 1'b0;
        w_uses_rt = 1'b0;
        case (w_op)
            OP_RTYPE: begin
                w_uses_rt = 1'b1;
                if (r_ifid_inst != NOP_INST) begin
                    w_ctrl[CTRL_REGWRITE] = 1'b1;
                    w_ctrl[CTRL_REGDST]   = 1'b1;
                    w_ctrl[CTRL_ALUOP_LO +: 3] = ALUOP_R;
                end
            end
            OP_LW: begin
                w_ctrl[CTRL_REGWRITE] = 1'b1;
                w_ctrl[CTRL_MEMREAD]  = 1'b1;
                w_ctrl[CTRL_MEMTOREG] = 1'b1;
                w_ctrl[CTRL_ALUSRC]   = 1'b1;
                w_ctrl[CTRL_ALUOP_LO +: 3] = ALUOP_ADD;
            end
            OP_SW: begin
                w_uses_rt = 1'b1;
                w_ctrl[CTRL_MEMWRITE] = 1'b1;
                w_ctrl[CTRL_ALUSRC]   = 1'b1;
                w_ctrl[CTRL_ALUOP_LO +: 3] = ALUOP_ADD;
            end
            OP_ADDI: begin
                w_ctrl[CTRL_REGWRITE] = 1'b1;
                w_ctrl[CTRL_ALUSRC]   = 1'b1;
                w_ctrl[CTRL_ALUOP_LO +: 3] = ALUOP_ADD;
            end
            OP_BEQ: begin
                w_is_beq  = 1'b1;
                w_uses_rt = 1'b1;
            end
            OP_BNE: begin
                w_is_bne  = 1'b1;
                w_uses_rt = 1'b1;
            end
            OP_J:    w_is_j = 1'b1;
            default: w_ctrl = '0;
        endcase
    end

    assign w_load_use  = bus.ex_memRead && (bus.ex_dest != 5'd0) &&
                         ((bus.ex_dest == w_rs) || (w_uses_rt && (bus.ex_dest == w_rt)));
    assign w_br_hazard = (w_is_beq || w_is_bne) && bus.ex_regWrite && (bus.ex_dest != 5'd0) &&
                         ((bus.ex_dest == w_rs) || (bus.ex_dest == w_rt));
    assign w_stall     = w_load_use || w_br_hazard;

    assign w_taken = !w_stall && ((w_is_beq && (w_rs_data == w_rt_data)) ||
                                  (w_is_bne && (w_rs_data != w_rt_data)));
    assign w_jump  = !w_stall && w_is_j;
    assign w_flush = w_taken || w_jump;

    assign bus.PCWrite       = !w_stall;
    assign bus.branch        = w_taken;
    assign bus.branchAddress = w_pc4 + {w_imm[29:0], 2'b00};
    assign bus.jump          = w_jump;
    assign bus.jumpAddress   = {w_pc4[31:28], r_ifid_inst[25:0], 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ifid_pc   <= 32'd0;
            r_ifid_inst <= NOP_INST;
        end else if (w_flush) begin
            r_ifid_pc   <= bus.IFtoID_PC;
            r_ifid_inst <= NOP_INST;
        end else if (!w_stall) begin
            r_ifid_pc   <= bus.IFtoID_PC;
            r_ifid_inst <= bus.IFtoID_inst;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || w_stall) begin
            r_idex_pc      <= 32'd0;
            r_idex_rs_data <= 32'd0;
            r_idex_rt_data <= 32'd0;
            r_idex_imm     <= 32'd0;
            r_idex_rs      <= 5'd0;
            r_idex_rt      <= 5'd0;
            r_idex_rd      <= 5'd0;
            r_idex_ctrl    <= '0;
        end else begin
            r_idex_pc      <= w_pc4;
            r_idex_rs_data <= w_rs_data;
            r_idex_rt_data <= w_rt_data;
            r_idex_imm     <= w_imm;
            r_idex_rs      <= w_rs;
            r_idex_rt      <= w_rt;
            r_idex_rd      <= w_rd;
            r_idex_ctrl    <= w_ctrl;
        end
    end

    assign bus.IDtoEX_PC     = r_idex_pc;
    assign bus.IDtoEX_rsData = r_idex_rs_data;
    assign bus.IDtoEX_rtData = r_idex_rt_data;
    assign bus.IDtoEX_imm    = r_idex_imm;
    assign bus.IDtoEX_rs     = r_idex_rs;
    assign bus.IDtoEX_rt     = r_idex_rt;
    assign bus.IDtoEX_rd     = r_idex_rd;
    assign bus.IDtoEX_ctrl   = r_idex_ctrl;

endmodule

`default_nettype wire

// File: tb/tb_id_stage.sv
// ============================================================================
// Module  : tb_id_stage
// Brief   : Directed self-checking bench for id_stage.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_id_stage;

    localparam logic [31:0] I_ADD_3_5_0  = 32'h00A0_1820;
    localparam logic [31:0] I_ADD_3_0_5  = 32'h0005_1820;
    localparam logic [31:0] I_ADD_9_8_10 = 32'h010A_4820;
    localparam logic [31:0] I_ADD_3_5_1  = 32'h00A1_1820;
    localparam logic [31:0] I_BEQ_1_2_3  = 32'h1022_0003;
    localparam logic [31:0] I_BNE_1_2_3  = 32'h1422_0003;
    localparam logic [31:0] I_BEQ_1_1_0  = 32'h1021_0000;
    localparam logic [31:0] I_BEQ_1_1_3  = 32'h1021_0003;
    localparam logic [31:0] I_J_100      = 32'h0800_0100;
    localparam logic [31:0] CTRL_RTYPE   = 32'h0000_010C;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    id_stage_if #(.CTRL_W(9)) bus ();

    id_stage u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [4:0] addr, input logic [31:0] data);
        bus.IFtoID_inst = 32'd0;
        bus.wb_we       = 1'b1;
        bus.wb_addr     = addr;
        bus.wb_data     = data;
        step();
        bus.wb_we       = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.IFtoID_PC   = 32'd0;
        bus.IFtoID_inst = 32'd0;
        bus.wb_we       = 1'b0;
        bus.wb_addr     = 5'd0;
        bus.wb_data     = 32'd0;
        bus.ex_regWrite = 1'b0;
        bus.ex_memRead  = 1'b0;
        bus.ex_dest     = 5'd0;
        step();
        step();
        chk("rst_ctrl", 32'(bus.IDtoEX_ctrl), 32'd0);
        chk("rst_pc", bus.IDtoEX_PC, 32'd0);
        chk("rst_pcwrite", 32'(bus.PCWrite), 32'd1);
        chk("rst_branch", 32'(bus.branch), 32'd0);
        chk("rst_jump", 32'(bus.jump), 32'd0);
        rst = 1'b0;

        // write-back bypass and $0
        bus.IFtoID_PC = 32'h20; bus.IFtoID_inst = I_ADD_3_5_0;
        step();
        bus.wb_we = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'hDEAD_BEEF;
        bus.IFtoID_PC = 32'h24; bus.IFtoID_inst = I_ADD_3_0_5;
        step();
        chk("byp_rsdata", bus.IDtoEX_rsData, 32'hDEAD_BEEF);
        chk("byp_ctrl", 32'(bus.IDtoEX_ctrl), CTRL_RTYPE);
        chk("byp_pc", bus.IDtoEX_PC, 32'h24);
        chk("byp_rd", 32'(bus.IDtoEX_rd), 32'd3);
        bus.wb_addr = 5'd0; bus.wb_data = 32'hFFFF_FFFF;
        step();
        chk("zero_rsdata", bus.IDtoEX_rsData, 32'd0);
        chk("stored_rtdata", bus.IDtoEX_rtData, 32'hDEAD_BEEF);
        bus.wb_we = 1'b0;

        wr(5'd1, 32'd7);
        wr(5'd2, 32'd7);
        wr(5'd10, 32'h55);

        // load-use stall
        bus.IFtoID_PC = 32'h100; bus.IFtoID_inst = I_ADD_9_8_10;
        step();
        bus.ex_memRead = 1'b1; bus.ex_dest = 5'd8;
        bus.IFtoID_PC = 32'h104; bus.IFtoID_inst = 32'd0;
        #1;
        chk("lu_pcwrite", 32'(bus.PCWrite), 32'd0);
        step();
        chk("lu_bubble_ctrl", 32'(bus.IDtoEX_ctrl), 32'd0);
        chk("lu_bubble_pc", bus.IDtoEX_PC, 32'd0);
        chk("lu_held_pcwrite", 32'(bus.PCWrite), 32'd0);
        bus.ex_memRead = 1'b0;
        #1;
        chk("lu_clear_pcwrite", 32'(bus.PCWrite), 32'd1);
        step();
        bus.ex_dest = 5'd0;
        chk("lu_issue_ctrl", 32'(bus.IDtoEX_ctrl), CTRL_RTYPE);
        chk("lu_issue_pc", bus.IDtoEX_PC, 32'h104);
        chk("lu_issue_rs", 32'(bus.IDtoEX_rs), 32'd8);
        chk("lu_issue_rt", 32'(bus.IDtoEX_rt), 32'd10);
        chk("lu_issue_rtdata", bus.IDtoEX_rtData, 32'h55);

        // taken beq and flushed slot
        bus.IFtoID_PC = 32'h40; bus.IFtoID_inst = I_BEQ_1_2_3;
        step();
        chk("beq_taken", 32'(bus.branch), 32'd1);
        chk("beq_target", bus.branchAddress, 32'h50);
        chk("beq_pcwrite", 32'(bus.PCWrite), 32'd1);
        bus.IFtoID_PC = 32'h44; bus.IFtoID_inst = I_ADD_3_5_0;
        step();
        chk("beq_idex_ctrl", 32'(bus.IDtoEX_ctrl), 32'd0);
        chk("beq_idex_pc", bus.IDtoEX_PC, 32'h44);
        chk("beq_idex_imm", bus.IDtoEX_imm, 32'd3);
        chk("flush_branch", 32'(bus.branch), 32'd0);
        step();
        chk("flush_rd", 32'(bus.IDtoEX_rd), 32'd0);
        chk("flush_ctrl", 32'(bus.IDtoEX_ctrl), 32'd0);

        wr(5'd2, 32'd8);
        bus.IFtoID_PC = 32'h40; bus.IFtoID_inst = I_BEQ_1_2_3;
        step();
        chk("beq_not_taken", 32'(bus.branch), 32'd0);
        bus.IFtoID_inst = I_BNE_1_2_3;
        step();
        chk("bne_taken", 32'(bus.branch), 32'd1);
        chk("bne_target", bus.branchAddress, 32'h50);
        bus.IFtoID_inst = 32'd0;
        step();
        bus.IFtoID_PC = 32'hFFFF_FFFC; bus.IFtoID_inst = I_BEQ_1_1_0;
        step();
        chk("wrap_taken", 32'(bus.branch), 32'd1);
        chk("wrap_target", bus.branchAddress, 32'h0);
        bus.IFtoID_inst = 32'd0;
        step();

        // jump
        bus.IFtoID_PC = 32'h1000_0000; bus.IFtoID_inst = I_J_100;
        step();
        chk("j_taken", 32'(bus.jump), 32'd1);
        chk("j_target", bus.jumpAddress, 32'h1000_0400);
        bus.IFtoID_PC = 32'h1000_0004; bus.IFtoID_inst = I_ADD_3_5_0;
        step();
        chk("j_flush_jump", 32'(bus.jump), 32'd0);
        step();
        chk("j_flush_rd", 32'(bus.IDtoEX_rd), 32'd0);

        // branch operand hazard
        bus.ex_regWrite = 1'b1; bus.ex_dest = 5'd1;
        bus.IFtoID_PC = 32'h40; bus.IFtoID_inst = I_BEQ_1_1_3;
        step();
        chk("bh_pcwrite", 32'(bus.PCWrite), 32'd0);
        chk("bh_branch", 32'(bus.branch), 32'd0);
        bus.IFtoID_PC = 32'h44; bus.IFtoID_inst = I_ADD_3_5_0;
        step();
        chk("bh_bubble_imm", bus.IDtoEX_imm, 32'd0);
        chk("bh_held_pcwrite", 32'(bus.PCWrite), 32'd0);
        chk("bh_held_branch", 32'(bus.branch), 32'd0);
        bus.ex_regWrite = 1'b0;
        #1;
        chk("bh_clear_pcwrite", 32'(bus.PCWrite), 32'd1);
        chk("bh_clear_branch", 32'(bus.branch), 32'd1);
        chk("bh_clear_target", bus.branchAddress, 32'h50);
        step();
        bus.ex_dest = 5'd0;
        chk("bh_issue_imm", bus.IDtoEX_imm, 32'd3);
        chk("bh_issue_pc", bus.IDtoEX_PC, 32'h44);

        // reset mid-stream
        bus.IFtoID_PC = 32'h200; bus.IFtoID_inst = I_ADD_3_5_1;
        step();
        step();
        step();
        chk("pre_rst_rsdata", bus.IDtoEX_rsData, 32'hDEAD_BEEF);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_ctrl", 32'(bus.IDtoEX_ctrl), 32'd0);
        chk("mid_rst_rsdata", bus.IDtoEX_rsData, 32'd0);
        chk("mid_rst_pc", bus.IDtoEX_PC, 32'd0);
        chk("mid_rst_pcwrite", 32'(bus.PCWrite), 32'd1);
        step();
        rst = 1'b0;
        step();
        step();
        chk("post_rst_ctrl", 32'(bus.IDtoEX_ctrl), CTRL_RTYPE);
        chk("post_rst_rsdata", bus.IDtoEX_rsData, 32'd0);
        chk("post_rst_rtdata", bus.IDtoEX_rtData, 32'd0);
        chk("post_rst_pc", bus.IDtoEX_PC, 32'h204);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
